// File: rtl/regfile_copy_engine.sv
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 5
`endif

// ============================================================================
// Module   : regfile_copy_engine
// Purpose  : Sequential copy / fill engine driving a single-port register
//            file. Copy alternates READ and WRITE one word at a time in
//            ascending order. Fill writes one word per cycle. Addresses wrap
//            modulo 2**AW.
// Ports    : clk           - clock, rising edge
//            rst           - asynchronous active-high reset
//            i_start       - command request, sampled only in IDLE
//            i_mode        - 0 = copy, 1 = fill
//            i_src_addr    - copy source base address
//            i_dst_addr    - destination base address
//            i_length      - word count, 0 .. 2**AW
//            i_fill_data   - fill-mode word
//            i_rf_data     - register file read data (combinational)
//            o_rf_address  - register file address
//            o_rf_data     - register file write data
//            o_rf_write_en - register file write enable
//            o_busy        - high in READ and WRITE
//            o_done        - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module regfile_copy_engine #(
  parameter int DW = `DATA_WIDTH,
  parameter int AW = `DATA_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic [AW-1:0] i_src_addr,
  input  logic [AW-1:0] i_dst_addr,
  input  logic [AW:0]   i_length,
  input  logic [DW-1:0] i_fill_data,
  input  logic [DW-1:0] i_rf_data,
  output logic [AW-1:0] o_rf_address,
  output logic [DW-1:0] o_rf_data,
  output logic          o_rf_write_en,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;

  logic          mode_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic [DW-1:0] fill_q;
  logic [AW:0]   idx;
  logic [DW-1:0] hold;

  // idx is one bit wider than an address so a length of 2**AW can be
  // compared exactly; the address sums use only the low AW bits and wrap.
  logic [AW:0]   idx_next;
  logic          last_word;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;

  assign idx_next  = idx + 1'b1;
  assign last_word = (idx_next == len_q);
  assign src_ptr   = src_q + idx[AW-1:0];
  assign dst_ptr   = dst_q + idx[AW-1:0];

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      idx    <= '0;
      hold   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (i_start) begin
            mode_q <= i_mode;
            src_q  <= i_src_addr;
            dst_q  <= i_dst_addr;
            len_q  <= i_length;
            fill_q <= i_fill_data;
            idx    <= '0;
          end
        end
        READ:    hold <= i_rf_data;
        WRITE:   idx  <= idx_next;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs. Outputs decode the state register directly, so
  // an asynchronous reset drops them immediately without a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    o_rf_address  = '0;
    o_rf_data     = '0;
    o_rf_write_en = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_length == '0) begin
            next_state = DONE;
          end else if (i_mode) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        o_busy       = 1'b1;
        o_rf_address = src_ptr;
        next_state   = WRITE;
      end
      WRITE: begin
        o_busy        = 1'b1;
        o_rf_address  = dst_ptr;
        o_rf_write_en = 1'b1;
        o_rf_data     = mode_q ? fill_q : hold;
        if (last_word) begin
          next_state = DONE;
        end else if (mode_q) begin
          next_state = WRITE;
        end else begin
          next_state = READ;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_copy_engine.sv
`default_nettype none

// ============================================================================
// Module   : tb_regfile_copy_engine
// Purpose  : Directed bench pairing the engine with a register file model.
//            Expected writes are queued when a command is issued and checked
//            in order as the engine presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_copy_engine;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_mode;
  logic [AW-1:0] i_src_addr;
  logic [AW-1:0] i_dst_addr;
  logic [AW:0]   i_length;
  logic [DW-1:0] i_fill_data;
  logic [DW-1:0] i_rf_data;
  logic [AW-1:0] o_rf_address;
  logic [DW-1:0] o_rf_data;
  logic          o_rf_write_en;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  regfile_copy_engine #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_src_addr    (i_src_addr),
    .i_dst_addr    (i_dst_addr),
    .i_length      (i_length),
    .i_fill_data   (i_fill_data),
    .i_rf_data     (i_rf_data),
    .o_rf_address  (o_rf_address),
    .o_rf_data     (o_rf_data),
    .o_rf_write_en (o_rf_write_en),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // Register file model: combinational read, write on rising edge.
  logic [DW-1:0] rf [DEPTH];
  logic          rf_clear;
  int            commits;

  assign i_rf_data = rf[o_rf_address];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      commits <= 0;
    end else if (o_rf_write_en) begin
      rf[o_rf_address] <= o_rf_data;
      commits          <= commits + 1;
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] exp_rf [DEPTH];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every presented write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (o_rf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        assert (0) else begin
          fails++;
          $error("FAIL unexpected_write observed addr=%0d data=%0h expected no write",
                 o_rf_address, o_rf_data);
        end
      end else begin
        mon_e = exp_q.pop_front();
        tests++;
        assert ({o_rf_address, o_rf_data} === {mon_e.a, mon_e.d}) else begin
          fails++;
          $error("FAIL write_order observed addr=%0d data=%0h expected addr=%0d data=%0h",
                 o_rf_address, o_rf_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  // Reference behaviour: ascending word-by-word copy that sees its own
  // earlier writes; only the first 'apply' writes land in the model.
  task automatic push_cmd(input logic mode, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input logic [AW:0] len,
                          input logic [DW-1:0] fill, input int apply);
    logic [DW-1:0] tmp [DEPTH];
    logic [AW-1:0] sa, da;
    wr_t           e;
    tmp = exp_rf;
    for (int i = 0; i < int'(len); i++) begin
      sa = src + AW'(i);
      da = dst + AW'(i);
      e.a = da;
      e.d = mode ? fill : tmp[sa];
      tmp[da] = e.d;
      exp_q.push_back(e);
      if (i < apply) exp_rf[da] = e.d;
    end
  endtask

  task automatic check_rf(input string tag);
    for (int a = 0; a < DEPTH; a++)
      chk($sformatf("%s_rf%0d", tag, a), 64'(rf[a]), 64'(exp_rf[a]));
  endtask

  task automatic run_cmd(input string tag, input logic mode, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input logic [AW:0] len,
                         input logic [DW-1:0] fill, input bit disturb);
    int lat, base, cyc, busy_after;
    bit seen;
    push_cmd(mode, src, dst, len, fill, int'(len));
    base = commits;
    @(negedge clk);
    i_mode = mode; i_src_addr = src; i_dst_addr = dst;
    i_length = len; i_fill_data = fill; i_start = 1'b1;
    if (len == 0)  lat = 1;
    else if (mode) lat = int'(len) + 1;
    else           lat = 2 * int'(len) + 1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) i_start = 1'b0;
      if (disturb && cyc == 3) begin
        i_start = 1'b1; i_mode = ~mode; i_src_addr = src + 5'd7;
        i_dst_addr = dst + 5'd9; i_length = 6'd2; i_fill_data = 32'h5555_AAAA;
      end
      if (disturb && cyc == 4) i_start = 1'b0;
      if (o_done === 1'b1) seen = 1;
      else chk($sformatf("%s_busy_c%0d", tag, cyc), 64'(o_busy), 64'(len != 0));
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy_in_done"}, 64'(o_busy), 64'd0);
    if (disturb) begin
      i_start = 1'b1; i_mode = 1'b1; i_dst_addr = 5'd0;
      i_length = 6'd3; i_fill_data = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    busy_after = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_after++;
    end
    chk({tag, "_no_restart"}, 64'(busy_after), 64'd0);
    chk({tag, "_write_count"}, 64'(commits - base), 64'(len));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_idle_outs"}, {o_rf_address, o_rf_data, o_rf_write_en, o_done},
        64'd0);
  endtask

  int base_abort;
  int guard;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; rf_clear = 1'b1; i_start = 1'b0; i_mode = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_length = '0; i_fill_data = '0;
    for (int i = 0; i < DEPTH; i++) exp_rf[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_we",   64'(o_rf_write_en), 64'd0);
    chk("reset_addr", 64'(o_rf_address), 64'd0);
    chk("reset_data", 64'(o_rf_data), 64'd0);
    rf_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Preload rf[4..7] through single-word fills, then copy with disturbances.
    run_cmd("pre_a0", 1'b1, 5'd0, 5'd4, 6'd1, 32'hA000_0000, 1'b0);
    run_cmd("pre_a1", 1'b1, 5'd0, 5'd5, 6'd1, 32'hA111_1111, 1'b0);
    run_cmd("pre_a2", 1'b1, 5'd0, 5'd6, 6'd1, 32'hA222_2222, 1'b0);
    run_cmd("pre_a3", 1'b1, 5'd0, 5'd7, 6'd1, 32'hA333_3333, 1'b0);
    run_cmd("copy", 1'b0, 5'd4, 5'd20, 6'd4, 32'h0, 1'b1);
    chk("copy_rf23", 64'(rf[23]), 64'h0000_0000_A333_3333);
    chk("copy_src7", 64'(rf[7]),  64'h0000_0000_A333_3333);
    check_rf("copy");

    run_cmd("fill_wrap", 1'b1, 5'd0, 5'd30, 6'd4, 32'hDEAD_BEEF, 1'b0);
    chk("fill_wrap_rf0", 64'(rf[0]), 64'h0000_0000_DEAD_BEEF);
    check_rf("fill_wrap");

    run_cmd("zero_len", 1'b0, 5'd3, 5'd9, 6'd0, 32'h0, 1'b0);

    run_cmd("pre_o0", 1'b1, 5'd0, 5'd0, 6'd1, 32'd1, 1'b0);
    run_cmd("pre_o1", 1'b1, 5'd0, 5'd1, 6'd1, 32'd2, 1'b0);
    run_cmd("pre_o2", 1'b1, 5'd0, 5'd2, 6'd1, 32'd3, 1'b0);
    run_cmd("pre_o3", 1'b1, 5'd0, 5'd3, 6'd1, 32'd4, 1'b0);
    run_cmd("overlap", 1'b0, 5'd0, 5'd1, 6'd3, 32'h0, 1'b0);
    chk("overlap_rf3", 64'(rf[3]), 64'd1);
    check_rf("overlap");

    run_cmd("full_fill", 1'b1, 5'd0, 5'd17, 6'd32, 32'h1234_5678, 1'b0);
    check_rf("full_fill");

    // Reset abort after the fifth committed write.
    push_cmd(1'b1, 5'd0, 5'd8, 6'd32, 32'hC0FF_EE00, 5);
    base_abort = commits;
    @(negedge clk);
    i_mode = 1'b1; i_src_addr = 5'd0; i_dst_addr = 5'd8;
    i_length = 6'd32; i_fill_data = 32'hC0FF_EE00; i_start = 1'b1;
    guard = 0;
    while ((commits - base_abort) < 5 && guard < 100) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      guard++;
    end
    chk("abort_reached5", 64'(commits - base_abort), 64'd5);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_we",   64'(o_rf_write_en), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_addr", 64'(o_rf_address), 64'd0);
    chk("abort_data", 64'(o_rf_data), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_write_count", 64'(commits - base_abort), 64'd5);
    exp_q.delete();
    rst = 1'b0;
    check_rf("abort");
    run_cmd("after_reset", 1'b0, 5'd8, 5'd16, 6'd3, 32'h0, 1'b0);
    check_rf("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
